seg7_scan_scheduler: RTL and testbench

Time-multiplexing scan controller for the four-digit seven-segment display on the board. It sits between the Gray counter's N-bit count value and the display pins. It splits the value into hex nibbles and drives one digit at a time, inserting a dark blanking slot between digits to suppress ghosting. New values are latched at frame boundaries only, so a count change never tears a frame.

---
 rtl/seg7_pkg.sv | 31 +++
 rtl/hex_to_seg7.sv | 11 +
 rtl/seg7_scan_scheduler.sv | 147 ++++++++++++++
 tb/tb_seg7_scan_scheduler.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the four-digit seven-segment scan controller.
// The segment table is active-low, ordered {a,b,c,d,e,f,g}, indexed by hex value.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 4;

    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Scan controller: alternates dark blanking slots with one lit digit, latching
// new display values only on the frame-start commit edge so frames never tear.
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int N         = 8,
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 1000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] data_in,
    input  logic         data_valid,
    output logic [3:0]   an,
    output logic [6:0]   seg,
    output logic         frame_done
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [2:0]    USED_DIGITS = 3'((N + 3) / 4);

    state_e        state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  disp_q, disp_d;
    logic [N-1:0]  pend_q, pend_d;
    logic          pend_v_q, pend_v_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          frame_done_q, frame_done_d;
    logic          commit_s;
    logic [15:0]   disp_ext_s;
    logic [3:0]    nib_s;
    logic [6:0]    seg_dec_s;

    // Outputs are decoded from the next state so they change on the same edge.
    assign disp_ext_s = 16'(disp_d);
    assign nib_s      = disp_ext_s[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib_i (nib_s),
        .seg_o (seg_dec_s)
    );

    // Next-state logic: slot sequencing, value capture/commit and output decode.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        frame_done_d = 1'b0;
        commit_s     = 1'b0;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        an_d         = 4'b1111;
        seg_d        = 7'b1111111;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d  = ST_ON;
                    cnt_d    = '0;
                    commit_s = (idx_q == 2'd0);
                end else begin
                    state_d = ST_BLANK;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d      = ST_BLANK;
                    cnt_d        = '0;
                    idx_d        = idx_q + 2'd1;
                    frame_done_d = (idx_q == 2'd3);
                end else begin
                    state_d = ST_ON;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        if (data_valid) begin
            pend_d   = data_in;
            pend_v_d = 1'b1;
        end else begin
            pend_d   = pend_q;
        end

        // A strobe landing on the commit edge bypasses the pending register.
        if (commit_s) begin
            if (data_valid) begin
                disp_d = data_in;
            end else if (pend_v_q) begin
                disp_d = pend_q;
            end else begin
                disp_d = disp_q;
            end
            pend_v_d = 1'b0;
        end else begin
            disp_d = disp_q;
        end

        // Digits beyond the data width stay dark but still occupy their slot.
        if (state_d == ST_ON && {1'b0, idx_d} < USED_DIGITS) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = seg_dec_s;
        end else begin
            an_d  = 4'b1111;
            seg_d = 7'b1111111;
        end
    end

    // State, data and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_BLANK;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Self-checking bench: a timeline model derived from edge counts since reset,
// cross-checked every cycle, plus hand-computed literal checkpoints.
module tb_seg7_scan_scheduler;

    localparam int N = 8, ON_CYC = 4, BLANK_CYC = 2;
    localparam int SLOT = ON_CYC + BLANK_CYC;
    localparam int FRAME = 4 * SLOT;
    localparam int USED = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       frame_done;

    int n_chk = 0;
    int n_fail = 0;

    logic [6:0] seg_ref [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg7_scan_scheduler #(.N(N), .ON_CYC(ON_CYC), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .an         (an),
        .seg        (seg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: m_k counts edges since the last reset edge; m_shown is the frame value.
    int         m_k = 0;
    logic       m_live = 1'b0;
    logic       m_pv = 1'b0;
    logic [7:0] m_pend = 8'h00;
    logic [7:0] m_shown = 8'h00;

    always @(posedge clk) begin
        if (reset) begin
            m_k <= 0; m_pv <= 1'b0; m_pend <= 8'h00; m_shown <= 8'h00; m_live <= 1'b1;
        end else begin
            m_k <= m_k + 1;
            if ((m_k + 1) % FRAME == BLANK_CYC) begin
                if (data_valid) m_shown <= data_in;
                else if (m_pv) m_shown <= m_pend;
                m_pv <= 1'b0;
            end else if (data_valid) begin
                m_pend <= data_in;
                m_pv   <= 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_live) begin
            int p, dig;
            logic [3:0] e_an;
            p   = m_k % SLOT;
            dig = (m_k / SLOT) % 4;
            e_an = (p >= BLANK_CYC && dig < USED) ? ~(4'b0001 << dig) : 4'b1111;
            chk("model_an", {28'd0, an}, {28'd0, e_an});
            chk("model_fd", {31'd0, frame_done}, {31'd0, (m_k > 0 && m_k % FRAME == 0)});
            chk("onehot_an", {31'd0, ($countones(~an) <= 1)}, 32'd1);
            if (p < BLANK_CYC)
                chk("model_seg_dark", {25'd0, seg}, {25'd0, 7'b1111111});
            else if (dig < USED)
                chk("model_seg", {25'd0, seg}, {25'd0, seg_ref[4'((m_shown >> (4 * dig)) & 8'hF)]});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg);
        chk({name, "_an"}, {28'd0, an}, {28'd0, e_an});
        chk({name, "_seg"}, {25'd0, seg}, {25'd0, e_seg});
    endtask

    initial begin
        reset = 1'b1;
        step(3);
        lit("reset", 4'b1111, 7'b1111111);
        chk("reset_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;                                   // k = 0 here
        step(1);  lit("post_rst_dark", 4'b1111, 7'b1111111);
        step(1);  lit("d0_zero", 4'b1110, 7'b0000001);  // k = 2
        step(6);  lit("d1_zero", 4'b1101, 7'b0000001);  // k = 8
        data_in = 8'hA5; data_valid = 1'b1;
        step(1);  data_valid = 1'b0;                    // k = 9
        lit("a5_not_yet", 4'b1101, 7'b0000001);
        step(17); lit("a5_d0", 4'b1110, 7'b0100100);    // k = 26
        step(6);  lit("a5_d1", 4'b1101, 7'b0001000);    // k = 32
        step(6);  chk("d2_unused", {28'd0, an}, 32'hF); // k = 38
        step(6);  chk("d3_unused", {28'd0, an}, 32'hF); // k = 44
        step(4);  chk("fd_pulse", {31'd0, frame_done}, 32'd1);  // k = 48
        step(1);  chk("fd_width", {31'd0, frame_done}, 32'd0);  // k = 49
        step(72);                                       // k = 121
        data_in = 8'h12; data_valid = 1'b1;
        step(1);  data_valid = 1'b0;                    // k = 122
        step(3);
        data_in = 8'h34; data_valid = 1'b1;
        step(1);  data_valid = 1'b0;                    // k = 126
        step(20); lit("last_wins_d0", 4'b1110, 7'b1001100);  // k = 146
        step(6);  lit("last_wins_d1", 4'b1101, 7'b0000110);  // k = 152
        step(17);                                       // k = 169
        data_in = 8'h7F; data_valid = 1'b1;
        step(1);  data_valid = 1'b0;                    // k = 170 commit edge
        lit("bypass_d0", 4'b1110, 7'b0111000);
        step(6);  lit("bypass_d1", 4'b1101, 7'b0001111);     // k = 176
        step(1);
        data_in = 8'h55; data_valid = 1'b1;
        step(1);  data_valid = 1'b0;                    // k = 178, 55 pending
        step(5);                                        // k = 183, digit 2 ON
        reset = 1'b1;
        step(1);  lit("midrst", 4'b1111, 7'b1111111);
        chk("midrst_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b0;
        step(2);  lit("rst2_d0", 4'b1110, 7'b0000001);  // k = 2
        step(6);  lit("rst2_d1", 4'b1101, 7'b0000001);  // k = 8
        step(18); lit("lost_d0", 4'b1110, 7'b0000001);  // k = 26
        step(6);  lit("lost_d1", 4'b1101, 7'b0000001);  // k = 32
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
